// File: rtl/sixteen_bit_barrel_shifter.sv
// rtl/sixteen_bit_barrel_shifter.sv - 16-bit bidirectional barrel rotator with registered output
//
// Purpose:
//   Rotates a 16-bit word left or right by 0..15 positions. Bits that leave
//   one end re-enter at the other. The result is registered, so it appears
//   exactly one clock after the inputs are sampled.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous active-high reset, clears the result
//   num          in  16   operand word
//   amt          in   4   rotate distance, unsigned 0..15
//   lr           in   1   direction: 0 = rotate left, 1 = rotate right
//   shifted_num  out 16   registered rotated result

module sixteen_bit_barrel_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] num,
  input  logic [3:0]  amt,
  input  logic        lr,
  output logic [15:0] shifted_num
);

  // Log-shifter stages: stage k rotates by 2^k when amt[k] is set.
  // Each stage selects between pass-through, rotate-left and rotate-right,
  // so every output bit is always driven from a real operand bit.
  logic [15:0] w_stage1;
  logic [15:0] w_stage2;
  logic [15:0] w_stage4;
  logic [15:0] w_stage8;
  logic [15:0] r_shifted;

  always_comb begin
    w_stage1 = num;
    if (amt[0]) begin
      if (lr) w_stage1 = {num[0], num[15:1]};
      else    w_stage1 = {num[14:0], num[15]};
    end
  end

  always_comb begin
    w_stage2 = w_stage1;
    if (amt[1]) begin
      if (lr) w_stage2 = {w_stage1[1:0], w_stage1[15:2]};
      else    w_stage2 = {w_stage1[13:0], w_stage1[15:14]};
    end
  end

  always_comb begin
    w_stage4 = w_stage2;
    if (amt[2]) begin
      if (lr) w_stage4 = {w_stage2[3:0], w_stage2[15:4]};
      else    w_stage4 = {w_stage2[11:0], w_stage2[15:12]};
    end
  end

  // A rotate by 8 is its own inverse on 16 bits, so both directions
  // produce the same word; the explicit mux is kept for symmetry.
  always_comb begin
    w_stage8 = w_stage4;
    if (amt[3]) begin
      if (lr) w_stage8 = {w_stage4[7:0], w_stage4[15:8]};
      else    w_stage8 = {w_stage4[7:0], w_stage4[15:8]};
    end
  end

  // Reset wins over data: a rotate sampled in the same edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) r_shifted <= 16'h0000;
    else     r_shifted <= w_stage8;
  end

  assign shifted_num = r_shifted;

endmodule

// File: tb/tb_sixteen_bit_barrel_shifter.sv
// tb/tb_sixteen_bit_barrel_shifter.sv - scoreboard bench for the 16-bit barrel rotator

module tb_sixteen_bit_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] num;
  logic [3:0]  amt;
  logic        lr;
  logic [15:0] shifted_num;

  logic [15:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  sixteen_bit_barrel_shifter dut (
    .clk         (clk),
    .rst         (rst),
    .num         (num),
    .amt         (amt),
    .lr          (lr),
    .shifted_num (shifted_num)
  );

  always #5 clk = ~clk;

  // Reference: move each bit individually to its destination index.
  function automatic logic [15:0] rot_model(input logic [15:0] n, input logic [3:0] a,
                                            input logic l);
    logic [15:0] r;
    int d;
    r = 16'h0000;
    d = l ? (16 - int'(a)) % 16 : int'(a);
    for (int i = 0; i < 16; i++) r[(i + d) % 16] = n[i];
    return r;
  endfunction

  // Drive one cycle of stimulus, queue its expected result, and step to
  // 1 time unit after the capturing edge.
  task automatic apply(input logic [15:0] n, input logic [3:0] a, input logic l,
                       input logic r, input logic [15:0] e);
    num = n;
    amt = a;
    lr  = l;
    rst = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    apply(16'hFFFF, 4'd5, 1'b0, 1'b1, 16'h0000);
    e = exp_q.pop_front();
    total_cnt++;
    if (shifted_num !== e) $display("FAIL reset_hold got=%h exp=%h", shifted_num, e);
    else pass_cnt++;
    apply(16'hFFFF, 4'd5, 1'b1, 1'b1, 16'h0000);
    e = exp_q.pop_front();
    total_cnt++;
    if (shifted_num !== e) $display("FAIL reset_hold2 got=%h exp=%h", shifted_num, e);
    else pass_cnt++;
    apply(16'h1234, 4'd4, 1'b0, 1'b0, 16'h2341);
    e = exp_q.pop_front();
    total_cnt++;
    if (shifted_num !== e) $display("FAIL reset_release got=%h exp=%h", shifted_num, e);
    else pass_cnt++;
  endtask

  task automatic test_left_sweep();
    logic [15:0] e;
    for (int n = 0; n < 16; n++) begin
      apply(16'(n), 4'd3, 1'b0, 1'b0, 16'(n << 3));
      e = exp_q.pop_front();
      total_cnt++;
      if (shifted_num !== e) $display("FAIL left_sweep n=%0d got=%h exp=%h", n, shifted_num, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_right_wrap();
    logic [15:0] e;
    for (int n = 0; n < 16; n++) begin
      apply(16'(n), 4'd3, 1'b1, 1'b0, rot_model(16'(n), 4'd3, 1'b1));
      e = exp_q.pop_front();
      total_cnt++;
      if (shifted_num !== e) $display("FAIL right_wrap n=%0d got=%h exp=%h", n, shifted_num, e);
      else pass_cnt++;
    end
    apply(16'h000F, 4'd3, 1'b1, 1'b0, 16'hE001);
    e = exp_q.pop_front();
    total_cnt++;
    if (shifted_num !== e) $display("FAIL right_wrap_f got=%h exp=%h", shifted_num, e);
    else pass_cnt++;
    apply(16'h0001, 4'd3, 1'b1, 1'b0, 16'h2000);
    e = exp_q.pop_front();
    total_cnt++;
    if (shifted_num !== e) $display("FAIL right_wrap_1 got=%h exp=%h", shifted_num, e);
    else pass_cnt++;
    apply(16'h0008, 4'd3, 1'b1, 1'b0, 16'h0001);
    e = exp_q.pop_front();
    total_cnt++;
    if (shifted_num !== e) $display("FAIL right_wrap_8 got=%h exp=%h", shifted_num, e);
    else pass_cnt++;
  endtask

  task automatic test_large_right();
    logic [15:0] e;
    for (int n = 0; n < 16; n++) begin
      apply(16'(n), 4'd11, 1'b1, 1'b0, 16'(n << 5));
      e = exp_q.pop_front();
      total_cnt++;
      if (shifted_num !== e) $display("FAIL large_right n=%0d got=%h exp=%h", n, shifted_num, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_edges();
    logic [15:0] vn [6] = '{16'hA5C3, 16'hA5C3, 16'h8001, 16'h8001, 16'h0001, 16'h0001};
    logic [3:0]  va [6] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd15, 4'd15};
    logic        vl [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] ve [6] = '{16'hA5C3, 16'hA5C3, 16'h0003, 16'hC000, 16'h8000, 16'h0002};
    logic [15:0] e;
    for (int i = 0; i < 6; i++) begin
      apply(vn[i], va[i], vl[i], 1'b0, ve[i]);
      e = exp_q.pop_front();
      total_cnt++;
      if (shifted_num !== e) $display("FAIL edge%0d got=%h exp=%h", i, shifted_num, e);
      else pass_cnt++;
    end
  endtask

  // Every amt/lr/one-hot combination, with random reset pulses inserted,
  // followed by fully random traffic; one new input set every cycle.
  task automatic test_back_to_back();
    logic [15:0] e;
    logic [15:0] n;
    logic [3:0]  a;
    logic        l;
    logic        r;
    for (int c = 0; c < 512; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        apply(16'($urandom), 4'($urandom), 1'($urandom), 1'b1, 16'h0000);
        e = exp_q.pop_front();
        total_cnt++;
        if (shifted_num !== e) $display("FAIL b2b_rst c=%0d got=%h exp=%h", c, shifted_num, e);
        else pass_cnt++;
      end
      n = 16'h0001 << (c % 16);
      a = 4'((c / 16) % 16);
      l = 1'(c / 256);
      apply(n, a, l, 1'b0, rot_model(n, a, l));
      e = exp_q.pop_front();
      total_cnt++;
      if (shifted_num !== e)
        $display("FAIL b2b_combo n=%h amt=%0d lr=%0d got=%h exp=%h", n, a, l, shifted_num, e);
      else pass_cnt++;
    end
    for (int c = 0; c < 300; c++) begin
      n = 16'($urandom);
      a = 4'($urandom);
      l = 1'($urandom);
      r = ($urandom_range(0, 9) == 0);
      apply(n, a, l, r, r ? 16'h0000 : rot_model(n, a, l));
      e = exp_q.pop_front();
      total_cnt++;
      if (shifted_num !== e)
        $display("FAIL b2b_rand n=%h amt=%0d lr=%0d rst=%0d got=%h exp=%h", n, a, l, r, shifted_num, e);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    num = 16'hFFFF;
    amt = 4'd0;
    lr  = 1'b0;
    test_reset();
    test_left_sweep();
    test_right_wrap();
    test_large_right();
    test_edges();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
